lsu_axi_master: RTL and testbench

- Downstream neighbour of the LSU: converts its level-style memory requests (re/we, address, wdata, byte mask) into AXI4-Lite master transactions on a 64-bit data bus.
- Returns load data right-aligned to bit 0, so the LSU's width/sign-extension logic works unchanged.
- One outstanding transaction at a time. The pipeline stalls on `req_ready` and `resp_valid`.

---
 rtl/ysyx_22050019_axi_pkg.sv | 28 ++
 rtl/lsu_axi_lane_align.sv | 20 ++
 rtl/lsu_axi_master.sv | 206 ++++++++++++++++++++
 tb/tb_lsu_axi_master.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050019_axi_pkg.sv
// Shared types and constants for the LSU AXI4-Lite master: FSM states, response codes
// and byte-lane shift helpers.
package ysyx_22050019_axi_pkg;

    localparam int unsigned DATA_W  = 64;
    localparam int unsigned STRB_W  = DATA_W / 8;
    localparam int unsigned OFF_W   = 3;
    localparam int unsigned SHAMT_W = OFF_W + 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WADDR,
        ST_WRESP,
        ST_RADDR,
        ST_RDATA,
        ST_DONE
    } lsu_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Byte offset within the 64-bit beat converted to a bit shift amount.
    function automatic logic [SHAMT_W-1:0] lane_shamt(input logic [OFF_W-1:0] off);
        return {off, 3'b000};
    endfunction

endpackage

// File: rtl/lsu_axi_lane_align.sv
// Byte-lane alignment between the LSU's right-aligned data and the 64-bit AXI beat.
module lsu_axi_lane_align
    import ysyx_22050019_axi_pkg::*;
(
    input  logic [OFF_W-1:0]  wr_off,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wmask,
    input  logic [OFF_W-1:0]  rd_off,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] wdata_c,
    output logic [STRB_W-1:0] wstrb_c,
    output logic [DATA_W-1:0] rdata_c
);

    // Bytes pushed past lane 7 fall off the top; misalignment is not trapped here.
    assign wdata_c = wdata << lane_shamt(wr_off);
    assign wstrb_c = wmask << wr_off;
    assign rdata_c = rdata >> lane_shamt(rd_off);

endmodule

// File: rtl/lsu_axi_master.sv
// Converts single-outstanding LSU load/store requests into AXI4-Lite transactions
// and returns load data right-aligned to bit 0.
module lsu_axi_master
    import ysyx_22050019_axi_pkg::*;
#(
    parameter int unsigned AXI_AW = 32,
    parameter int unsigned DW     = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_re,
    input  logic [63:0]       req_addr,
    input  logic [DW-1:0]     req_wdata,
    input  logic [7:0]        req_wmask,
    output logic              resp_valid,
    output logic [DW-1:0]     resp_rdata,
    output logic              resp_err,
    output logic              m_axi_aw_valid,
    input  logic              m_axi_aw_ready,
    output logic [AXI_AW-1:0] m_axi_aw_addr,
    output logic              m_axi_w_valid,
    input  logic              m_axi_w_ready,
    output logic [DW-1:0]     m_axi_w_data,
    output logic [7:0]        m_axi_w_strb,
    input  logic              m_axi_b_valid,
    output logic              m_axi_b_ready,
    input  logic [1:0]        m_axi_b_resp,
    output logic              m_axi_ar_valid,
    input  logic              m_axi_ar_ready,
    output logic [AXI_AW-1:0] m_axi_ar_addr,
    input  logic              m_axi_r_valid,
    output logic              m_axi_r_ready,
    input  logic [DW-1:0]     m_axi_r_data,
    input  logic [1:0]        m_axi_r_resp
);

    lsu_state_e        state_q, state_d;
    logic              aw_valid_q, aw_valid_d;
    logic              w_valid_q, w_valid_d;
    logic              b_ready_q, b_ready_d;
    logic              ar_valid_q, ar_valid_d;
    logic              r_ready_q, r_ready_d;
    logic [AXI_AW-1:0] aw_addr_q, aw_addr_d;
    logic [AXI_AW-1:0] ar_addr_q, ar_addr_d;
    logic [DW-1:0]     w_data_q, w_data_d;
    logic [7:0]        w_strb_q, w_strb_d;
    logic [OFF_W-1:0]  rd_off_q, rd_off_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [DW-1:0]     resp_rdata_q, resp_rdata_d;

    logic [DW-1:0]     wdata_sh_c;
    logic [7:0]        wstrb_sh_c;
    logic [DW-1:0]     rdata_sh_c;
    logic [AXI_AW-1:0] beat_addr_c;

    if (AXI_AW < 64) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^req_addr[63:AXI_AW];
    end

    assign beat_addr_c = {req_addr[AXI_AW-1:3], 3'b000};

    lsu_axi_lane_align u_lane_align (
        .wr_off  (req_addr[OFF_W-1:0]),
        .wdata   (req_wdata),
        .wmask   (req_wmask),
        .rd_off  (rd_off_q),
        .rdata   (m_axi_r_data),
        .wdata_c (wdata_sh_c),
        .wstrb_c (wstrb_sh_c),
        .rdata_c (rdata_sh_c)
    );

    // Next-state and registered-output logic; valids depend only on state and handshakes seen.
    always_comb begin
        state_d      = state_q;
        aw_valid_d   = aw_valid_q;
        w_valid_d    = w_valid_q;
        b_ready_d    = b_ready_q;
        ar_valid_d   = ar_valid_q;
        r_ready_d    = r_ready_q;
        aw_addr_d    = aw_addr_q;
        ar_addr_d    = ar_addr_q;
        w_data_d     = w_data_q;
        w_strb_d     = w_strb_q;
        rd_off_d     = rd_off_q;
        resp_valid_d = 1'b0;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_we) begin
                    state_d    = ST_WADDR;
                    aw_addr_d  = beat_addr_c;
                    w_data_d   = wdata_sh_c;
                    w_strb_d   = wstrb_sh_c;
                    aw_valid_d = 1'b1;
                    w_valid_d  = 1'b1;
                end else if (req_valid && req_re) begin
                    state_d    = ST_RADDR;
                    ar_addr_d  = beat_addr_c;
                    rd_off_d   = req_addr[OFF_W-1:0];
                    ar_valid_d = 1'b1;
                end
            end
            ST_WADDR: begin
                // AW and W retire independently; clearing a valid marks that channel done.
                if (aw_valid_q && m_axi_aw_ready) aw_valid_d = 1'b0;
                if (w_valid_q && m_axi_w_ready)   w_valid_d  = 1'b0;
                if (!aw_valid_d && !w_valid_d) begin
                    state_d   = ST_WRESP;
                    b_ready_d = 1'b1;
                end
            end
            ST_WRESP: begin
                if (m_axi_b_valid) begin
                    b_ready_d    = 1'b0;
                    resp_err_d   = (m_axi_b_resp != RESP_OKAY);
                    resp_valid_d = 1'b1;
                    state_d      = ST_DONE;
                end
            end
            ST_RADDR: begin
                if (m_axi_ar_ready) begin
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                    state_d    = ST_RDATA;
                end
            end
            ST_RDATA: begin
                if (m_axi_r_valid) begin
                    r_ready_d    = 1'b0;
                    resp_rdata_d = rdata_sh_c;
                    resp_err_d   = (m_axi_r_resp != RESP_OKAY);
                    resp_valid_d = 1'b1;
                    state_d      = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d    = ST_IDLE;
                aw_valid_d = 1'b0;
                w_valid_d  = 1'b0;
                b_ready_d  = 1'b0;
                ar_valid_d = 1'b0;
                r_ready_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            aw_valid_q   <= 1'b0;
            w_valid_q    <= 1'b0;
            b_ready_q    <= 1'b0;
            ar_valid_q   <= 1'b0;
            r_ready_q    <= 1'b0;
            aw_addr_q    <= '0;
            ar_addr_q    <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            rd_off_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            aw_valid_q   <= aw_valid_d;
            w_valid_q    <= w_valid_d;
            b_ready_q    <= b_ready_d;
            ar_valid_q   <= ar_valid_d;
            r_ready_q    <= r_ready_d;
            aw_addr_q    <= aw_addr_d;
            ar_addr_q    <= ar_addr_d;
            w_data_q     <= w_data_d;
            w_strb_q     <= w_strb_d;
            rd_off_q     <= rd_off_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign req_ready      = (state_q == ST_IDLE);
    assign resp_valid     = resp_valid_q;
    assign resp_err       = resp_err_q;
    assign resp_rdata     = resp_rdata_q;
    assign m_axi_aw_valid = aw_valid_q;
    assign m_axi_aw_addr  = aw_addr_q;
    assign m_axi_w_valid  = w_valid_q;
    assign m_axi_w_data   = w_data_q;
    assign m_axi_w_strb   = w_strb_q;
    assign m_axi_b_ready  = b_ready_q;
    assign m_axi_ar_valid = ar_valid_q;
    assign m_axi_ar_addr  = ar_addr_q;
    assign m_axi_r_ready  = r_ready_q;

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed bench for lsu_axi_master: stimulus at the falling edge, outputs sampled there too.
module tb_lsu_axi_master;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic        req_re;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        m_axi_aw_valid;
    logic        m_axi_aw_ready;
    logic [31:0] m_axi_aw_addr;
    logic        m_axi_w_valid;
    logic        m_axi_w_ready;
    logic [63:0] m_axi_w_data;
    logic [7:0]  m_axi_w_strb;
    logic        m_axi_b_valid;
    logic        m_axi_b_ready;
    logic [1:0]  m_axi_b_resp;
    logic        m_axi_ar_valid;
    logic        m_axi_ar_ready;
    logic [31:0] m_axi_ar_addr;
    logic        m_axi_r_valid;
    logic        m_axi_r_ready;
    logic [63:0] m_axi_r_data;
    logic [1:0]  m_axi_r_resp;

    int pass_cnt;
    int total_cnt;

    lsu_axi_master #(.AXI_AW(32), .DW(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_re         (req_re),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_wmask      (req_wmask),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .m_axi_aw_valid (m_axi_aw_valid),
        .m_axi_aw_ready (m_axi_aw_ready),
        .m_axi_aw_addr  (m_axi_aw_addr),
        .m_axi_w_valid  (m_axi_w_valid),
        .m_axi_w_ready  (m_axi_w_ready),
        .m_axi_w_data   (m_axi_w_data),
        .m_axi_w_strb   (m_axi_w_strb),
        .m_axi_b_valid  (m_axi_b_valid),
        .m_axi_b_ready  (m_axi_b_ready),
        .m_axi_b_resp   (m_axi_b_resp),
        .m_axi_ar_valid (m_axi_ar_valid),
        .m_axi_ar_ready (m_axi_ar_ready),
        .m_axi_ar_addr  (m_axi_ar_addr),
        .m_axi_r_valid  (m_axi_r_valid),
        .m_axi_r_ready  (m_axi_r_ready),
        .m_axi_r_data   (m_axi_r_data),
        .m_axi_r_resp   (m_axi_r_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic idle_slave();
        m_axi_aw_ready = 1'b0;
        m_axi_w_ready  = 1'b0;
        m_axi_b_valid  = 1'b0;
        m_axi_b_resp   = 2'b00;
        m_axi_ar_ready = 1'b0;
        m_axi_r_valid  = 1'b0;
        m_axi_r_data   = 64'h0;
        m_axi_r_resp   = 2'b00;
    endtask

    // Present a request for one rising edge; returns at the falling edge of cycle N+1.
    task automatic issue(input logic we, input logic re, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [7:0] mask);
        req_valid = 1'b1;
        req_we    = we;
        req_re    = re;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = mask;
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_re    = 1'b0;
    endtask

    // Cycle index (accept cycle = 0) at which resp_valid is seen; 20 means timeout.
    task automatic wait_resp(output int cyc);
        cyc = 1;
        while (resp_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_re = 1'b0;
        req_addr = 64'h0; req_wdata = 64'h0; req_wmask = 8'h0;
        idle_slave();
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({m_axi_aw_valid, m_axi_w_valid, m_axi_b_ready, m_axi_ar_valid, m_axi_r_ready,
             resp_valid, resp_err} !== 7'b0)
            $display("FAIL reset_ctrl got %b exp 0000000", {m_axi_aw_valid, m_axi_w_valid,
                     m_axi_b_ready, m_axi_ar_valid, m_axi_r_ready, resp_valid, resp_err});
        else pass_cnt++;
        total_cnt++;
        if ({resp_rdata, m_axi_w_data, m_axi_w_strb, m_axi_aw_addr, m_axi_ar_addr} !== '0)
            $display("FAIL reset_data rdata=%h wdata=%h strb=%h aw=%h ar=%h exp all 0",
                     resp_rdata, m_axi_w_data, m_axi_w_strb, m_axi_aw_addr, m_axi_ar_addr);
        else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b exp 1", req_ready);
        else pass_cnt++;
    endtask

    task automatic test_aligned_sd();
        int cyc;
        m_axi_aw_ready = 1'b1; m_axi_w_ready = 1'b1; m_axi_b_valid = 1'b1; m_axi_b_resp = 2'b00;
        issue(1'b1, 1'b0, 64'h8000_0000, 64'h1122334455667788, 8'hFF);
        total_cnt++;
        if ({m_axi_aw_valid, m_axi_w_valid} !== 2'b11)
            $display("FAIL sd_valids got %b exp 11", {m_axi_aw_valid, m_axi_w_valid});
        else pass_cnt++;
        total_cnt++;
        if (m_axi_aw_addr !== 32'h8000_0000 || m_axi_w_strb !== 8'hFF ||
            m_axi_w_data !== 64'h1122334455667788)
            $display("FAIL sd_payload addr=%h strb=%h data=%h exp 80000000 ff 1122334455667788",
                     m_axi_aw_addr, m_axi_w_strb, m_axi_w_data);
        else pass_cnt++;
        wait_resp(cyc);
        total_cnt++;
        if (cyc !== 3 || resp_err !== 1'b0)
            $display("FAIL sd_resp cycle=%0d err=%b exp cycle 3 err 0", cyc, resp_err);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({resp_valid, req_ready} !== 2'b01)
            $display("FAIL sd_after got resp_valid,req_ready=%b exp 01", {resp_valid, req_ready});
        else pass_cnt++;
        idle_slave();
    endtask

    task automatic test_misaligned_sb();
        int cyc;
        m_axi_aw_ready = 1'b1; m_axi_w_ready = 1'b1; m_axi_b_valid = 1'b1; m_axi_b_resp = 2'b00;
        issue(1'b1, 1'b0, 64'h8000_0005, 64'h0000_0000_0000_00AB, 8'h01);
        total_cnt++;
        if (m_axi_aw_addr !== 32'h8000_0000 || m_axi_w_strb !== 8'h20 ||
            m_axi_w_data !== 64'h0000AB0000000000)
            $display("FAIL sb_payload addr=%h strb=%h data=%h exp 80000000 20 0000ab0000000000",
                     m_axi_aw_addr, m_axi_w_strb, m_axi_w_data);
        else pass_cnt++;
        wait_resp(cyc);
        total_cnt++;
        if (cyc !== 3) $display("FAIL sb_latency got %0d exp 3", cyc);
        else pass_cnt++;
        @(negedge clk);
        idle_slave();
    endtask

    task automatic test_ignored();
        logic seen;
        seen = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_re = 1'b0; req_addr = 64'h8000_0040;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            seen = seen | m_axi_aw_valid | m_axi_w_valid | m_axi_ar_valid | resp_valid;
        end
        req_valid = 1'b0;
        total_cnt++;
        if (seen !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL ignored_req activity=%b req_ready=%b exp 0 1", seen, req_ready);
        else pass_cnt++;
    endtask

    task automatic test_lh();
        int cyc;
        m_axi_ar_ready = 1'b1; m_axi_r_valid = 1'b1;
        m_axi_r_data = 64'hBEEF000000000000; m_axi_r_resp = 2'b00;
        issue(1'b0, 1'b1, 64'h8000_0006, 64'h0, 8'h0);
        total_cnt++;
        if ({m_axi_ar_valid, m_axi_aw_valid} !== 2'b10 || m_axi_ar_addr !== 32'h8000_0000)
            $display("FAIL lh_ar ar_valid,aw_valid=%b addr=%h exp 10 80000000",
                     {m_axi_ar_valid, m_axi_aw_valid}, m_axi_ar_addr);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({m_axi_ar_valid, m_axi_r_ready} !== 2'b01)
            $display("FAIL lh_rdata_state ar_valid,r_ready=%b exp 01", {m_axi_ar_valid, m_axi_r_ready});
        else pass_cnt++;
        wait_resp(cyc);
        cyc++;
        total_cnt++;
        if (cyc !== 3 || resp_rdata !== 64'h000000000000BEEF)
            $display("FAIL lh_resp cycle=%0d rdata=%h exp 3 000000000000beef", cyc, resp_rdata);
        else pass_cnt++;
        idle_slave();
        repeat (2) @(negedge clk);
        total_cnt++;
        if (resp_rdata !== 64'h000000000000BEEF)
            $display("FAIL lh_hold got %h exp 000000000000beef", resp_rdata);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int cyc;
        m_axi_ar_ready = 1'b1; m_axi_r_valid = 1'b1;
        m_axi_r_data = 64'h00000000000000C3; m_axi_r_resp = 2'b00;
        req_valid = 1'b1; req_we = 1'b0; req_re = 1'b1; req_addr = 64'h8000_0080;
        @(negedge clk);
        wait_resp(cyc);
        total_cnt++;
        if (cyc !== 3 || req_ready !== 1'b0)
            $display("FAIL b2b_first cycle=%0d req_ready=%b exp 3 0", cyc, req_ready);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (req_ready !== 1'b1) $display("FAIL b2b_ready got %b exp 1", req_ready);
        else pass_cnt++;
        @(negedge clk);
        req_valid = 1'b0; req_re = 1'b0;
        total_cnt++;
        if (m_axi_ar_valid !== 1'b1) $display("FAIL b2b_second_ar got %b exp 1", m_axi_ar_valid);
        else pass_cnt++;
        wait_resp(cyc);
        total_cnt++;
        if (cyc !== 3 || resp_rdata !== 64'hC3)
            $display("FAIL b2b_second cycle=%0d rdata=%h exp 3 c3", cyc, resp_rdata);
        else pass_cnt++;
        @(negedge clk);
        idle_slave();
    endtask

    task automatic test_backpressure();
        logic [8:1]  aw_hist, w_hist, b_hist, rv_hist;
        logic [31:0] addr_c3;
        int          resp_cnt;
        resp_cnt = 0;
        addr_c3  = 32'h0;
        m_axi_aw_ready = 1'b0; m_axi_w_ready = 1'b1; m_axi_b_valid = 1'b1; m_axi_b_resp = 2'b00;
        issue(1'b1, 1'b0, 64'h8000_0100, 64'h000000000000DEAD, 8'h03);
        for (int c = 1; c <= 8; c++) begin
            aw_hist[c] = m_axi_aw_valid;
            w_hist[c]  = m_axi_w_valid;
            b_hist[c]  = m_axi_b_ready;
            rv_hist[c] = resp_valid;
            if (c == 3) addr_c3 = m_axi_aw_addr;
            if (resp_valid === 1'b1) resp_cnt++;
            m_axi_aw_ready = (c == 3);
            @(negedge clk);
        end
        total_cnt++;
        if (w_hist[2:1] !== 2'b01) $display("FAIL bp_w_valid c2,c1=%b exp 01", w_hist[2:1]);
        else pass_cnt++;
        total_cnt++;
        if (aw_hist[4:1] !== 4'b0111) $display("FAIL bp_aw_valid c4..c1=%b exp 0111", aw_hist[4:1]);
        else pass_cnt++;
        total_cnt++;
        if (addr_c3 !== 32'h8000_0100) $display("FAIL bp_aw_addr got %h exp 80000100", addr_c3);
        else pass_cnt++;
        total_cnt++;
        if (b_hist[4:3] !== 2'b10) $display("FAIL bp_b_ready c4,c3=%b exp 10", b_hist[4:3]);
        else pass_cnt++;
        total_cnt++;
        if (resp_cnt !== 1 || rv_hist[5] !== 1'b1)
            $display("FAIL bp_resp count=%0d at_c5=%b exp 1 1", resp_cnt, rv_hist[5]);
        else pass_cnt++;
        idle_slave();
    endtask

    task automatic test_error_priority();
        logic ar_seen, aw_seen, err_at_resp;
        int   cyc;
        ar_seen = 1'b0; aw_seen = 1'b0; err_at_resp = 1'b0;
        m_axi_aw_ready = 1'b1; m_axi_w_ready = 1'b1; m_axi_b_valid = 1'b1; m_axi_b_resp = 2'b10;
        m_axi_ar_ready = 1'b1;
        issue(1'b1, 1'b1, 64'h8000_0020, 64'h1, 8'h01);
        for (int c = 1; c <= 6; c++) begin
            ar_seen = ar_seen | m_axi_ar_valid;
            aw_seen = aw_seen | m_axi_aw_valid;
            if (resp_valid === 1'b1) err_at_resp = resp_err;
            @(negedge clk);
        end
        total_cnt++;
        if ({ar_seen, aw_seen} !== 2'b01)
            $display("FAIL prio_channels ar_seen,aw_seen=%b exp 01", {ar_seen, aw_seen});
        else pass_cnt++;
        total_cnt++;
        if (err_at_resp !== 1'b1) $display("FAIL write_err got %b exp 1", err_at_resp);
        else pass_cnt++;
        total_cnt++;
        if (resp_rdata !== 64'hC3) $display("FAIL write_keeps_rdata got %h exp c3", resp_rdata);
        else pass_cnt++;
        idle_slave();
        m_axi_ar_ready = 1'b1; m_axi_r_valid = 1'b1;
        m_axi_r_data = 64'h0000000000001234; m_axi_r_resp = 2'b00;
        issue(1'b0, 1'b1, 64'h8000_0000, 64'h0, 8'h0);
        wait_resp(cyc);
        total_cnt++;
        if (cyc !== 3 || resp_err !== 1'b0 || resp_rdata !== 64'h1234)
            $display("FAIL read_ok cycle=%0d err=%b rdata=%h exp 3 0 1234", cyc, resp_err, resp_rdata);
        else pass_cnt++;
        @(negedge clk);
        idle_slave();
    endtask

    task automatic test_reset_mid();
        logic rv_seen;
        int   cyc;
        rv_seen = 1'b0;
        m_axi_ar_ready = 1'b1;
        issue(1'b0, 1'b1, 64'h8000_0009, 64'h0, 8'h0);
        @(negedge clk);
        total_cnt++;
        if (m_axi_r_ready !== 1'b1) $display("FAIL mid_in_rdata r_ready got %b exp 1", m_axi_r_ready);
        else pass_cnt++;
        #2;
        rst = 1'b1;
        m_axi_r_valid = 1'b1;
        m_axi_r_data  = 64'h000000000000AA00;
        #1;
        total_cnt++;
        if ({m_axi_aw_valid, m_axi_w_valid, m_axi_b_ready, m_axi_ar_valid, m_axi_r_ready,
             resp_valid} !== 6'b0 || resp_rdata !== 64'h0)
            $display("FAIL mid_async ctrl=%b rdata=%h exp 000000 0", {m_axi_aw_valid, m_axi_w_valid,
                     m_axi_b_ready, m_axi_ar_valid, m_axi_r_ready, resp_valid}, resp_rdata);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            rv_seen = rv_seen | resp_valid;
        end
        total_cnt++;
        if (rv_seen !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL mid_no_resp resp_seen=%b req_ready=%b exp 0 1", rv_seen, req_ready);
        else pass_cnt++;
        issue(1'b0, 1'b1, 64'h8000_0009, 64'h0, 8'h0);
        wait_resp(cyc);
        total_cnt++;
        if (cyc !== 3 || resp_rdata !== 64'hAA)
            $display("FAIL mid_recover cycle=%0d rdata=%h exp 3 aa", cyc, resp_rdata);
        else pass_cnt++;
        @(negedge clk);
        idle_slave();
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_aligned_sd();
        test_misaligned_sb();
        test_ignored();
        test_lh();
        test_back_to_back();
        test_backpressure();
        test_error_priority();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
